// File: rtl/log_mem_ctrl_pkg.sv
// Shared constants for the debug log capture/readback controller:
// default widths and the FSM state encoding.
package log_mem_ctrl_pkg;

    localparam int LOG_NB_DATA = 32;
    localparam int LOG_NB_ADDR = 15;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

endpackage

// File: rtl/log_ram.sv
// Simple dual-port log RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module log_ram #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 15
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [NB_ADDR-1:0] wr_addr,
    input  logic [NB_DATA-1:0] wr_data,
    input  logic               rd_en,
    input  logic [NB_ADDR-1:0] rd_addr,
    output logic [NB_DATA-1:0] rd_data
);

    logic [NB_DATA-1:0] mem [0:(1<<NB_ADDR)-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/log_mem_ctrl.sv
// Debug log controller: fills log_ram with consecutive valid samples after a
// run pulse, then serves 2-cycle-latency random-access reads once idle/full.
module log_mem_ctrl
    import log_mem_ctrl_pkg::*;
#(
    parameter int NB_DATA = LOG_NB_DATA,
    parameter int NB_ADDR = LOG_NB_ADDR
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_run_log,
    input  logic               i_read_log,
    input  logic [NB_ADDR-1:0] i_addr_log,
    input  logic               i_data_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_mem_full,
    output logic               o_busy,
    output logic [NB_DATA-1:0] o_data_log
);

    // Sample handshake: a sample is consumed on every rising edge where
    // i_data_valid=1 in CAPTURE, except the run-pulse cycle (run wins).
    logic [1:0]         state;
    logic [NB_ADDR-1:0] wr_ptr;
    logic               wr_en;
    logic               last_wr;
    logic               rd_issue;
    logic [NB_ADDR-1:0] rd_addr_q;
    logic               rd_vld_q;
    logic               ram_vld_q;
    logic [NB_DATA-1:0] ram_rd_data;

    assign wr_en    = (state == ST_CAPTURE) && i_data_valid && !i_run_log;
    assign last_wr  = wr_en && (wr_ptr == {NB_ADDR{1'b1}});
    assign rd_issue = i_read_log && (state != ST_CAPTURE);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
        end else if (i_run_log) begin
            state  <= ST_CAPTURE;
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (last_wr) begin
                state <= ST_FULL;
            end
        end
    end

    // Flags decode the state register only, so no input reaches them combinationally.
    assign o_busy     = (state == ST_CAPTURE);
    assign o_mem_full = (state == ST_FULL);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_addr_q  <= '0;
            rd_vld_q   <= 1'b0;
            ram_vld_q  <= 1'b0;
            o_data_log <= '0;
        end else begin
            rd_vld_q  <= rd_issue;
            ram_vld_q <= rd_vld_q;
            if (rd_issue) begin
                rd_addr_q <= i_addr_log;
            end
            if (ram_vld_q) begin
                o_data_log <= ram_rd_data;
            end
        end
    end

    log_ram #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR)
    ) u_log_ram (
        .clock  (clock),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(i_data),
        .rd_en  (rd_vld_q),
        .rd_addr(rd_addr_q),
        .rd_data(ram_rd_data)
    );

endmodule

// File: tb/tb_log_mem_ctrl.sv
// Directed bench for log_mem_ctrl with a 16-word log: reset, capture, readback
// latency, restart, blocked reads and run coincident with the last write.
module tb_log_mem_ctrl;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 4;

    logic               clock;
    logic               i_reset;
    logic               i_run_log;
    logic               i_read_log;
    logic [NB_ADDR-1:0] i_addr_log;
    logic               i_data_valid;
    logic [NB_DATA-1:0] i_data;
    logic               o_mem_full;
    logic               o_busy;
    logic [NB_DATA-1:0] o_data_log;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic               run;
        logic               rd;
        logic [NB_ADDR-1:0] addr;
        logic               valid;
        logic [NB_DATA-1:0] data;
        logic               exp_busy;
        logic               exp_full;
        logic               chk_dat;
        logic [NB_DATA-1:0] exp_dat;
    } vec_t;

    vec_t tbl[12];

    log_mem_ctrl #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_run_log   (i_run_log),
        .i_read_log  (i_read_log),
        .i_addr_log  (i_addr_log),
        .i_data_valid(i_data_valid),
        .i_data      (i_data),
        .o_mem_full  (o_mem_full),
        .o_busy      (o_busy),
        .o_data_log  (o_data_log)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the edge that used them.
    task automatic cyc(input logic run, input logic rd, input logic [NB_ADDR-1:0] addr,
                       input logic valid, input logic [NB_DATA-1:0] data);
        i_run_log    = run;
        i_read_log   = rd;
        i_addr_log   = addr;
        i_data_valid = valid;
        i_data       = data;
        @(posedge clock);
        #1;
        i_run_log    = 1'b0;
        i_read_log   = 1'b0;
        i_data_valid = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [NB_ADDR-1:0] addr,
                            input logic [NB_DATA-1:0] exp);
        cyc(1'b0, 1'b1, addr, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, addr, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, addr, 1'b0, 32'h0);
        check(name, o_data_log, exp);
    endtask

    task automatic flags(input string name, input logic busy, input logic full);
        check({name, "_busy"}, {31'd0, o_busy}, {31'd0, busy});
        check({name, "_full"}, {31'd0, o_mem_full}, {31'd0, full});
    endtask

    initial begin
        // rows: run rd addr valid data | busy full chk_dat exp_dat
        tbl[0]  = '{1'b0, 1'b1, 4'd0,  1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hC003};
        tbl[1]  = '{1'b0, 1'b1, 4'd5,  1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hC003};
        tbl[2]  = '{1'b0, 1'b1, 4'd15, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA000};
        tbl[3]  = '{1'b0, 1'b0, 4'd15, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA005};
        tbl[4]  = '{1'b0, 1'b0, 4'd15, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA00F};
        tbl[5]  = '{1'b0, 1'b0, 4'd3,  1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA00F};
        tbl[6]  = '{1'b0, 1'b0, 4'd3,  1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA00F};
        tbl[7]  = '{1'b1, 1'b0, 4'd3,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA00F};
        tbl[8]  = '{1'b0, 1'b1, 4'd3,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA00F};
        tbl[9]  = '{1'b0, 1'b1, 4'd3,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA00F};
        tbl[10] = '{1'b0, 1'b1, 4'd3,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA00F};
        tbl[11] = '{1'b0, 1'b1, 4'd3,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA00F};

        i_reset      = 1'b0;
        i_run_log    = 1'b0;
        i_read_log   = 1'b0;
        i_addr_log   = '0;
        i_data_valid = 1'b0;
        i_data       = '0;
        #2;
        flags("por", 1'b0, 1'b0);
        check("por_data", o_data_log, 32'h0);
        @(posedge clock);
        #1;
        i_reset = 1'b1;

        // reset asserted mid-capture
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'hD000 + k);
        check("pre_rst_ptr", {28'd0, dut.wr_ptr}, 32'd5);
        #3;
        i_reset = 1'b0;
        #1;
        flags("async_rst", 1'b0, 1'b0);
        check("async_rst_data", o_data_log, 32'h0);
        check("async_rst_state", {30'd0, dut.state}, 32'd0);
        check("async_rst_ptr", {28'd0, dut.wr_ptr}, 32'd0);
        @(posedge clock);
        #1;
        i_reset = 1'b1;

        // fresh capture after reset lands at address 0 onward
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        flags("run1", 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'hC000 + k);
            if (k == 14) flags("cap1_15", 1'b1, 1'b0);
        end
        flags("cap1_full", 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, (k < 4), k[NB_ADDR-1:0], 1'b0, 32'h0);
            if (k >= 2) check($sformatf("rd1_addr%0d", k - 2), o_data_log, 32'hC000 + k - 2);
        end

        // full capture with valid every other cycle, then an extra strobe
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        flags("run2", 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'hA000 + k);
            if (k == 14) flags("cap2_15", 1'b1, 1'b0);
            if (k == 15) flags("cap2_16", 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 4'd0, 1'b0, 32'hEEEE);
        end
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'hFFFF);
        flags("extra_valid", 1'b0, 1'b1);
        check("extra_valid_ptr", {28'd0, dut.wr_ptr}, 32'd0);

        // readback latency, hold, then reads blocked in CAPTURE
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].run, tbl[i].rd, tbl[i].addr, tbl[i].valid, tbl[i].data);
            flags($sformatf("tbl%0d", i), tbl[i].exp_busy, tbl[i].exp_full);
            if (tbl[i].chk_dat) check($sformatf("tbl%0d_data", i), o_data_log, tbl[i].exp_dat);
        end

        // restart mid-capture; pulse-cycle sample discarded
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h9000 + k);
        check("pre_restart_ptr", {28'd0, dut.wr_ptr}, 32'd7);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 32'h9999);
        flags("restart", 1'b1, 1'b0);
        check("restart_ptr", {28'd0, dut.wr_ptr}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'hB000 + k);
            if (k == 14) flags("cap3_15", 1'b1, 1'b0);
        end
        flags("cap3_full", 1'b0, 1'b1);
        rd_check("rd3_addr0", 4'd0, 32'hB000);
        rd_check("rd3_addr7", 4'd7, 32'hB007);
        rd_check("rd3_addr15", 4'd15, 32'hB00F);

        // run coincident with the last write
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h5000 + k);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 32'h500F);
        flags("run_last", 1'b1, 1'b0);
        check("run_last_ptr", {28'd0, dut.wr_ptr}, 32'd0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
        flags("run_last_next", 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h7777);
        for (int k = 1; k < 16; k++) cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h6000 + k);
        flags("cap4_full", 1'b0, 1'b1);
        rd_check("rd4_addr0", 4'd0, 32'h7777);
        rd_check("rd4_addr1", 4'd1, 32'h6001);
        rd_check("rd4_addr14", 4'd14, 32'h600E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
